// File: rtl/timer_sequence_ctrl.sv
// timer_sequence_ctrl
// Control FSM that sits in front of a 4-bit shift/down-count register.
// It hunts for the serial start pattern 1101, then enables 4 shift cycles
// so the counter captures a delay value MSB first. Next it paces the counter's
// decrement with a prescaler, raises done, and waits for ack.
// shift_ena, counting and done are registered alongside the state. count_ena
// is decoded from registers only: state, prescaler and the counter's value.
module timer_sequence_ctrl #(
    parameter int PRESCALE = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data,
    input  logic [3:0] count_val,
    input  logic       ack,
    output logic       shift_ena,
    output logic       count_ena,
    output logic       counting,
    output logic       done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [3:0] {
        S0,
        S1,
        S11,
        S110,
        SH0,
        SH1,
        SH2,
        SH3,
        CNT,
        DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          presc_wrap;

    assign presc_wrap = (presc == PMAX);

    // A count step is issued on the last prescaler cycle. It is never issued
    // at zero, so the counter never wraps from 0 to 15.
    assign count_ena = counting && presc_wrap && (count_val != 4'd0);

    // Sequencer: pattern search, shift window, paced count, done/ack handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S0;
            presc     <= '0;
            shift_ena <= 1'b0;
            counting  <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Outputs reflect the state being entered; the prescaler idles at 0.
            shift_ena <= 1'b0;
            counting  <= 1'b0;
            done      <= 1'b0;
            presc     <= '0;
            case (state)
                S0:   state <= data ? S1 : S0;
                S1:   state <= data ? S11 : S0;
                S11:  state <= data ? S11 : S110;
                S110: begin
                    if (data) begin
                        state     <= SH0;
                        shift_ena <= 1'b1;
                    end else begin
                        state <= S0;
                    end
                end
                SH0: begin
                    state     <= SH1;
                    shift_ena <= 1'b1;
                end
                SH1: begin
                    state     <= SH2;
                    shift_ena <= 1'b1;
                end
                SH2: begin
                    state     <= SH3;
                    shift_ena <= 1'b1;
                end
                SH3: begin
                    state    <= CNT;
                    counting <= 1'b1;
                end
                CNT: begin
                    if (!presc_wrap) begin
                        presc    <= presc + PW'(1);
                        counting <= 1'b1;
                    end else if (count_val == 4'd0) begin
                        // The final prescale period at zero has elapsed.
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        counting <= 1'b1;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state <= S0;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= S0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_sequence_ctrl.sv
// Bench for timer_sequence_ctrl with PRESCALE=4 and a behavioural
// shift/down-count register closing the loop on count_val.
// The stimulus queues the expected result of each timing run. A monitor
// gathers what the DUT does on each falling edge and checks it when done rises
// and when done falls.
module tb_timer_sequence_ctrl;

    localparam int P = 4;

    logic       clk;
    logic       rst_n;
    logic       data;
    logic       ack;
    logic [3:0] cnt_q;
    logic       shift_ena;
    logic       count_ena;
    logic       counting;
    logic       done;

    timer_sequence_ctrl #(.PRESCALE(P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .count_val (cnt_q),
        .ack       (ack),
        .shift_ena (shift_ena),
        .count_ena (count_ena),
        .counting  (counting),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream shift/down-count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         cnt_q <= 4'd0;
        else if (shift_ena) cnt_q <= {cnt_q[2:0], data};
        else if (count_ena) cnt_q <= cnt_q - 4'd1;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        int shift_start;
        int val;
        int pulses;
        int cnt_cycles;
        int done_len;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_bit(input logic b);
        data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
    endtask

    // One full sequence: prefix pattern, 4 delay bits, wait for done, then
    // either hold done for 'hold' cycles and ack, or (spur) keep ack high.
    task automatic run(input logic [15:0] pre, input int npre, input logic [3:0] v,
                       input int hold, input logic [19:0] hb, input logic spur);
        exp_t e;
        bit   seen;
        ack = spur;
        send_bits(pre, npre);
        e.shift_start = cyc;
        e.val         = int'(v);
        e.pulses      = int'(v);
        e.cnt_cycles  = (int'(v) + 1) * P;
        e.done_len    = spur ? 1 : hold + 1;
        sb.push_back(e);
        send_bits({12'd0, v}, 4);
        data = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("done_reached", int'(seen), 1);
        if (!spur) begin
            for (int i = hold - 1; i >= 0; i--) send_bit(hb[i + 20 - hold]);
            ack = 1'b1;
        end
        @(posedge clk);
        #1;
        ack  = 1'b0;
        data = 1'b0;
    endtask

    // Monitor state.
    int   sh_start, sh_cnt, cnt_start, cnt_cyc, npulse, last_pulse, loaded, dlen;
    bit   bad, have_cur;
    logic prev_shift, prev_cnt, prev_done;
    exp_t cur;

    initial begin
        sh_start = 0; sh_cnt = 0; cnt_start = 0; cnt_cyc = 0; npulse = 0;
        last_pulse = 0; loaded = 0; dlen = 0; bad = 0; have_cur = 0;
        prev_shift = 0; prev_cnt = 0; prev_done = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sh_cnt = 0; cnt_cyc = 0; npulse = 0; bad = 0; dlen = 0;
                have_cur = 0; prev_shift = 0; prev_cnt = 0; prev_done = 0;
            end else begin
                if (shift_ena) begin
                    if (!prev_shift) sh_start = cyc;
                    sh_cnt++;
                end
                if (counting) begin
                    if (!prev_cnt) begin
                        cnt_start = cyc;
                        loaded    = int'(cnt_q);
                    end
                    cnt_cyc++;
                end
                if (count_ena) begin
                    if (!counting || cnt_q == 4'd0) bad = 1;
                    if (cyc != ((npulse == 0) ? cnt_start + P - 1 : last_pulse + P)) bad = 1;
                    last_pulse = cyc;
                    npulse++;
                end
                if (int'(shift_ena) + int'(count_ena) + int'(done) > 1) bad = 1;
                if (done && !prev_done) begin
                    if (!prev_cnt) bad = 1;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: got done=1, expected no run pending (cycle %0d)", cyc);
                    end else begin
                        cur = sb.pop_front();
                        have_cur = 1;
                        check("shift_start", sh_start, cur.shift_start);
                        check("shift_cycles", sh_cnt, 4);
                        check("loaded_value", loaded, cur.val);
                        check("count_pulses", npulse, cur.pulses);
                        check("counting_cycles", cnt_cyc, cur.cnt_cycles);
                        check("protocol_ok", int'(bad), 0);
                    end
                    sh_cnt = 0; cnt_cyc = 0; npulse = 0; bad = 0;
                    dlen = 1;
                end else if (done) begin
                    dlen++;
                end
                if (!done && prev_done && have_cur) begin
                    check("done_length", dlen, cur.done_len);
                    have_cur = 0;
                end
                prev_shift = shift_ena;
                prev_cnt   = counting;
                prev_done  = done;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        data  = 1'b0;
        ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_shift_ena", int'(shift_ena), 0);
        check("reset_count_ena", int'(count_ena), 0);
        check("reset_counting", int'(counting), 0);
        check("reset_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal load of 10.
        run(16'b1101, 4, 4'd10, 0, 20'd0, 1'b0);
        // Overlapping patterns.
        run(16'b11101, 5, 4'd2, 0, 20'd0, 1'b0);
        run(16'b101101, 6, 4'd1, 0, 20'd0, 1'b0);
        // Pattern embedded in the delay bits must not retrigger.
        run(16'b1101, 4, 4'b1101, 0, 20'd0, 1'b0);
        // Zero load.
        run(16'b1101, 4, 4'd0, 0, 20'd0, 1'b0);
        // Done held 20 cycles while data carries 1101 and ends in 110.
        run(16'b1101, 4, 4'd1, 20, 20'b1101_1011_0101_1101_0110, 1'b0);
        // Fresh detection after the long hold.
        run(16'b1101, 4, 4'd2, 0, 20'd0, 1'b0);

        // Asynchronous reset in the middle of counting, during a count step.
        send_bits(16'b1101, 4);
        send_bits(16'b1010, 4);
        data = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (count_ena) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("pre_reset_count_ena_seen", int'(seen), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_counting", int'(counting), 0);
        check("async_count_ena", int'(count_ena), 0);
        check("async_shift_ena", int'(shift_ena), 0);
        check("async_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(16'b1101, 4, 4'd3, 0, 20'd0, 1'b0);

        // ack held high through the whole run.
        run(16'b1101, 4, 4'd2, 0, 20'd0, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
